// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MEM-stage data-memory access unit:
//   - MIPS load/store opcode constants
//   - MEM FSM state encoding
//   - access-width enum and opcode decode helpers
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } width_e;

  // Unknown opcodes fall through to a full-word access.
  function automatic width_e width_of(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return W_BYTE;
      OP_LH, OP_LHU, OP_SH: return W_HALF;
      default:              return W_WORD;
    endcase
  endfunction

  function automatic logic sign_ext_of(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if
// Pipeline <-> MEM-stage bundle.
//   MemReadM/MemWriteM : load / store request for the instruction in MEM
//   opcodeM            : opcode (width and sign extension)
//   ALUOutM            : byte address
//   WriteDataM         : store data
//   ReadDataM          : registered load result
//   StallM             : access outstanding, pipeline frozen
//   AddrErrorM         : misaligned-access pulse
//   BusyM              : FSM not idle (debug)
// master = pipeline side, slave = memory stage.
// ---------------------------------------------------------------------------
interface mem_access_stage_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic [5:0]  opcodeM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        AddrErrorM;
  logic        BusyM;

  modport master (
    output MemReadM, MemWriteM, opcodeM, ALUOutM, WriteDataM,
    input  ReadDataM, StallM, AddrErrorM, BusyM
  );

  modport slave (
    input  MemReadM, MemWriteM, opcodeM, ALUOutM, WriteDataM,
    output ReadDataM, StallM, AddrErrorM, BusyM
  );
endinterface

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Combinational big-endian lane logic for byte/halfword/word accesses.
//   off_i        : byte offset within the word (address bits 1:0)
//   width_i      : access width
//   sign_ext_i   : sign-extend narrow loads
//   old_word_i   : current RAM word
//   store_data_i : store data (low bits used for narrow stores)
//   misalign_o   : access not naturally aligned for its width
//   merged_o     : old word with the addressed lane replaced
//   load_o       : extracted and extended load value
// Byte offset 0 is bits 31:24; halfword offset 0 is bits 31:16.
// ---------------------------------------------------------------------------
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]  off_i,
  input  width_e      width_i,
  input  logic        sign_ext_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] store_data_i,
  output logic        misalign_o,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statements can leave a latch behind.
  always_comb begin
    misalign_o = 1'b0;
    merged_o   = old_word_i;
    load_o     = old_word_i;
    byte_sel   = old_word_i[31:24];
    half_sel   = old_word_i[31:16];

    case (off_i)
      2'd0:    byte_sel = old_word_i[31:24];
      2'd1:    byte_sel = old_word_i[23:16];
      2'd2:    byte_sel = old_word_i[15:8];
      default: byte_sel = old_word_i[7:0];
    endcase
    half_sel = off_i[1] ? old_word_i[15:0] : old_word_i[31:16];

    case (width_i)
      W_BYTE: begin
        load_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
        case (off_i)
          2'd0:    merged_o = {store_data_i[7:0], old_word_i[23:0]};
          2'd1:    merged_o = {old_word_i[31:24], store_data_i[7:0], old_word_i[15:0]};
          2'd2:    merged_o = {old_word_i[31:16], store_data_i[7:0], old_word_i[7:0]};
          default: merged_o = {old_word_i[31:8], store_data_i[7:0]};
        endcase
      end
      W_HALF: begin
        misalign_o = off_i[0];
        load_o     = {{16{sign_ext_i & half_sel[15]}}, half_sel};
        merged_o   = off_i[1] ? {old_word_i[31:16], store_data_i[15:0]}
                              : {store_data_i[15:0], old_word_i[15:0]};
      end
      default: begin
        misalign_o = |off_i;
        load_o     = old_word_i;
        merged_o   = store_data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// MEM-stage data-memory access unit with a fixed multi-cycle latency.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   mem_if : slave side of mem_access_stage_if (requests in, ReadDataM,
//            StallM, AddrErrorM, BusyM out)
// An aligned access takes LATENCY+1 cycles: LATENCY stalled cycles (the
// launching IDLE cycle plus WAIT cycles) followed by one DONE cycle in which
// the pipeline is released and the store commits / load result registers.
// ---------------------------------------------------------------------------
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = 10,
  parameter int LATENCY         = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_stage_if.slave mem_if
);

  localparam int         DEPTH = 1 << ADDR_WORDS_LOG2;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  logic [31:0] ram [DEPTH];

  mem_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [5:0]  op_q, op_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req;
  logic        ram_we;
  logic        misalign;
  logic [1:0]  al_off;
  width_e      al_width;
  logic [31:0] old_word;
  logic [31:0] merged_word;
  logic [31:0] load_word;
  logic [ADDR_WORDS_LOG2-1:0] word_idx;

  assign req      = mem_if.MemReadM | mem_if.MemWriteM;
  assign word_idx = addr_q[ADDR_WORDS_LOG2+1:2];
  assign old_word = ram[word_idx];

  // In IDLE only the alignment check on the live request matters; afterwards
  // the aligner works entirely from the latched copies.
  assign al_off   = (state_q == ST_IDLE) ? mem_if.ALUOutM[1:0] : addr_q[1:0];
  assign al_width = (state_q == ST_IDLE) ? width_of(mem_if.opcodeM) : width_of(op_q);

  mem_lane_align u_align (
    .off_i        (al_off),
    .width_i      (al_width),
    .sign_ext_i   (sign_ext_of(op_q)),
    .old_word_i   (old_word),
    .store_data_i (wdata_q),
    .misalign_o   (misalign),
    .merged_o     (merged_word),
    .load_o       (load_word)
  );

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    op_d              = op_q;
    rd_d              = rd_q;
    wr_d              = wr_q;
    rdata_d           = rdata_q;
    ram_we            = 1'b0;
    mem_if.StallM     = 1'b0;
    mem_if.AddrErrorM = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (misalign) begin
            mem_if.AddrErrorM = 1'b1;
            rdata_d           = '0;
          end else begin
            mem_if.StallM = 1'b1;
            addr_d        = mem_if.ALUOutM;
            wdata_d       = mem_if.WriteDataM;
            op_d          = mem_if.opcodeM;
            rd_d          = mem_if.MemReadM;
            wr_d          = mem_if.MemWriteM;
            cnt_d         = 4'd1;
            // With a single stall cycle the launching cycle is the only one.
            state_d       = (LAT == 4'd1) ? ST_DONE : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        mem_if.StallM = 1'b1;
        cnt_d         = cnt_q + 4'd1;
        if (cnt_d == LAT) state_d = ST_DONE;
      end
      ST_DONE: begin
        // Requests still present here belong to the completing instruction.
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (wr_q) begin
          ram_we = 1'b1;
          if (rd_q) rdata_d = '0;
        end else begin
          rdata_d = load_word;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rst) begin
      mem_if.StallM     = 1'b0;
      mem_if.AddrErrorM = 1'b0;
      ram_we            = 1'b0;
    end
  end

  assign mem_if.BusyM     = (state_q != ST_IDLE) && !rst;
  assign mem_if.ReadDataM = rdata_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // NOTE: the RAM array is deliberately kept out of reset so it maps onto
  // memory primitives; ram_we is already masked while rst is high.
  always_ff @(posedge clk) begin
    if (ram_we) ram[word_idx] <= merged_word;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
// Directed bench for mem_access_stage (ADDR_WORDS_LOG2=10, LATENCY=2).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;
  import mips_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mem_access_stage_if mem_if ();

  mem_access_stage #(.ADDR_WORDS_LOG2(10), .LATENCY(LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .mem_if (mem_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_if.MemReadM   = 1'b0;
    mem_if.MemWriteM  = 1'b0;
    mem_if.opcodeM    = 6'h00;
    mem_if.ALUOutM    = '0;
    mem_if.WriteDataM = '0;
  endtask

  // Presents one instruction and holds it while StallM is high, exactly as
  // the frozen pipeline would. Returns once the instruction has advanced
  // (one edge past its last cycle), with inputs still driven.
  task automatic access(input logic rd, input logic wr, input logic [5:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int stalls, output int errs);
    bit done = 0;
    stalls = 0;
    errs   = 0;
    mem_if.MemReadM   = rd;
    mem_if.MemWriteM  = wr;
    mem_if.opcodeM    = op;
    mem_if.ALUOutM    = addr;
    mem_if.WriteDataM = wdata;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (mem_if.AddrErrorM === 1'b1) errs++;
      if (mem_if.StallM === 1'b1) stalls++;
      else done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) check("access_timeout", 32'd1, 32'd0);
  endtask

  // Issue an access, check its stall/error counts, then release the bus.
  task automatic op_chk(input string tag, input logic rd, input logic wr,
                        input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_stalls,
                        input int exp_errs);
    int s, e;
    access(rd, wr, op, addr, wdata, s, e);
    idle_inputs();
    check({tag, "_stalls"}, 32'(s), 32'(exp_stalls));
    check({tag, "_err"}, 32'(e), 32'(exp_errs));
  endtask

  task automatic load_chk(input string tag, input logic [5:0] op,
                          input logic [31:0] addr, input logic [31:0] exp);
    op_chk(tag, 1'b1, 1'b0, op, addr, 32'h0, LAT, 0);
    @(negedge clk);
    check({tag, "_data"}, mem_if.ReadDataM, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s1, s2, e1, e2;
    logic [31:0] held;

    idle_inputs();
    // Reset: outputs forced low while rst is high, registers cleared.
    repeat (2) @(posedge clk);
    #1;
    mem_if.MemReadM = 1'b1;
    @(negedge clk);
    check("rst_stall", 32'(mem_if.StallM), 32'd0);
    check("rst_busy", 32'(mem_if.BusyM), 32'd0);
    check("rst_rdata", mem_if.ReadDataM, 32'h0);
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(mem_if.BusyM), 32'd0);
    @(posedge clk);
    #1;

    // 1. SW then LW.
    op_chk("sw_10", 1'b0, 1'b1, OP_SW, 32'h10, 32'hDEADBEEF, LAT, 0);
    load_chk("lw_10", OP_LW, 32'h10, 32'hDEADBEEF);

    // 2. Byte store merge and narrow loads.
    op_chk("sb_12", 1'b0, 1'b1, OP_SB, 32'h12, 32'h00000055, LAT, 0);
    load_chk("lw_merge", OP_LW, 32'h10, 32'hDEAD55EF);
    load_chk("lb_10", OP_LB, 32'h10, 32'hFFFFFFDE);
    load_chk("lbu_10", OP_LBU, 32'h10, 32'h000000DE);
    load_chk("lh_12", OP_LH, 32'h12, 32'h000055EF);
    load_chk("lhu_10", OP_LHU, 32'h10, 32'h0000DEAD);
    load_chk("lb_13", OP_LB, 32'h13, 32'hFFFFFFEF);

    // 3. Misaligned accesses: single-cycle error, no stall, no write.
    mem_if.MemReadM = 1'b1;
    mem_if.opcodeM  = OP_LW;
    mem_if.ALUOutM  = 32'h13;
    @(negedge clk);
    check("mis_lw_err", 32'(mem_if.AddrErrorM), 32'd1);
    check("mis_lw_stall", 32'(mem_if.StallM), 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    check("mis_lw_pulse", 32'(mem_if.AddrErrorM), 32'd0);
    check("mis_lw_rdata", mem_if.ReadDataM, 32'h0);
    check("mis_lw_busy", 32'(mem_if.BusyM), 32'd0);
    @(posedge clk);
    #1;
    load_chk("lw_after_mis", OP_LW, 32'h10, 32'hDEAD55EF);
    op_chk("mis_sh", 1'b0, 1'b1, OP_SH, 32'h11, 32'h0000AAAA, 0, 1);
    load_chk("lw_after_sh", OP_LW, 32'h10, 32'hDEAD55EF);

    // Store with read also asserted: store wins, ReadDataM cleared.
    op_chk("sw_rw", 1'b1, 1'b1, OP_SW, 32'h30, 32'h0BADF00D, LAT, 0);
    @(negedge clk);
    check("sw_rw_rdata", mem_if.ReadDataM, 32'h0);
    @(posedge clk);
    #1;
    load_chk("lw_30", OP_LW, 32'h30, 32'h0BADF00D);

    // 4. Address wrap modulo 1024 words.
    op_chk("sw_wrap", 1'b0, 1'b1, OP_SW, 32'h00001000, 32'h12345678, LAT, 0);
    load_chk("lw_wrap", OP_LW, 32'h0, 32'h12345678);

    // 5. Reset in the first WAIT cycle abandons the store.
    op_chk("sw_20", 1'b0, 1'b1, OP_SW, 32'h20, 32'h11111111, LAT, 0);
    mem_if.MemWriteM  = 1'b1;
    mem_if.opcodeM    = OP_SW;
    mem_if.ALUOutM    = 32'h20;
    mem_if.WriteDataM = 32'hCAFEF00D;
    @(negedge clk);
    check("abort_launch_stall", 32'(mem_if.StallM), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_stall", 32'(mem_if.StallM), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("abort_stall", 32'(mem_if.StallM), 32'd0);
    check("abort_busy", 32'(mem_if.BusyM), 32'd0);
    @(posedge clk);
    #1;
    load_chk("lw_20", OP_LW, 32'h20, 32'h11111111);

    // 6. Back-to-back loads then a non-memory instruction.
    access(1'b1, 1'b0, OP_LW, 32'h10, 32'h0, s1, e1);
    access(1'b1, 1'b0, OP_LW, 32'h0, 32'h0, s2, e2);
    idle_inputs();
    check("b2b_stalls", 32'(s1 + s2), 32'(2 * LAT));
    check("b2b_err", 32'(e1 + e2), 32'd0);
    @(negedge clk);
    check("b2b_rdata", mem_if.ReadDataM, 32'h12345678);
    held = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      check("nonmem_stall", 32'(mem_if.StallM), 32'd0);
      check("nonmem_busy", 32'(mem_if.BusyM), 32'd0);
      check("nonmem_rdata", mem_if.ReadDataM, held);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
